// File: rtl/root_result_streamer.sv
// root_result_streamer
//
// Snapshots the decoder's roots vector when a decode completes (result_valid
// rises) or the decoder deadlocks (deadlock rises). It then streams the
// snapshot as one frame of 32-bit words over a valid/ready interface:
//   word 0            : test ID (zero-extended)
//   words 1..PU_COUNT : {8'b0, z, x, y} for PU 0..PU_COUNT-1, each field 8 bits
//   last word         : {dl_flag, cycle_counter[30:0]}
// The word layout matches the golden output-file format, so a host can compare
// frames line by line.
//
// Ports
//   clk           single clock
//   reset         asynchronous, active-low
//   result_valid  decoder result valid level
//   deadlock      decoder deadlock level
//   roots         root of each PU, PU n at [n*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   cycle_counter decoder cycle count for the current round
//   out_data      stream word
//   out_valid     out_data valid
//   out_ready     sink accepts the word when out_valid & out_ready
//   busy          a frame is in progress
//   overrun       sticky: a trigger arrived while busy and was dropped
//   drop_count    number of dropped triggers, saturating at 0xFFFF
module root_result_streamer #(
  parameter int unsigned CODE_DISTANCE_X = 5,
  parameter int unsigned CODE_DISTANCE_Z = 4,
  localparam int unsigned MEASUREMENT_ROUNDS =
    (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
  localparam int unsigned PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
  localparam int unsigned PER_DIMENSION_WIDTH =
    (MEASUREMENT_ROUNDS > 1) ? $clog2(MEASUREMENT_ROUNDS) : 1,
  localparam int unsigned ADDRESS_WIDTH = 3 * PER_DIMENSION_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                result_valid,
  input  logic                                deadlock,
  input  logic [ADDRESS_WIDTH*PU_COUNT-1:0]   roots,
  input  logic [31:0]                         cycle_counter,
  output logic [31:0]                         out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                overrun,
  output logic [15:0]                         drop_count
);

  localparam int unsigned IdxWidth = (PU_COUNT > 1) ? $clog2(PU_COUNT) : 1;
  localparam int unsigned Pdw      = PER_DIMENSION_WIDTH;

  // Each coordinate is emitted in an 8-bit field, so wider coordinates cannot
  // be represented in the output format.
  if (PER_DIMENSION_WIDTH > 8) begin : g_width_check
    $error("PER_DIMENSION_WIDTH must be <= 8");
  end

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StRoots,
    StTrailer
  } state_e;

  state_e                              state_q, state_d;
  logic [IdxWidth-1:0]                 idx_q, idx_d;
  logic [31:0]                         test_id_q, test_id_d;
  logic [ADDRESS_WIDTH*PU_COUNT-1:0]   snap_roots_q, snap_roots_d;
  logic [30:0]                         snap_cc_q, snap_cc_d;
  logic                                snap_dl_q, snap_dl_d;
  logic                                rv_q, dl_q;
  logic                                overrun_q, overrun_d;
  logic [15:0]                         drop_q, drop_d;

  logic trigger;
  logic handshake;
  logic capture;
  logic drop;

  // Bit 31 of the cycle counter is replaced by the deadlock flag in the trailer.
  logic unused_cc_msb;
  assign unused_cc_msb = cycle_counter[31];

  assign trigger   = (result_valid & ~rv_q) | (deadlock & ~dl_q);
  assign out_valid = (state_q != StIdle);
  assign busy      = out_valid;
  assign handshake = out_valid & out_ready;
  assign overrun   = overrun_q;
  assign drop_count = drop_q;

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    test_id_d    = test_id_q;
    snap_roots_d = snap_roots_q;
    snap_cc_d    = snap_cc_q;
    snap_dl_d    = snap_dl_q;
    overrun_d    = overrun_q;
    drop_d       = drop_q;
    capture      = 1'b0;
    drop         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          capture = 1'b1;
        end
      end
      StHeader: begin
        if (handshake) begin
          state_d = StRoots;
          idx_d   = '0;
        end
      end
      StRoots: begin
        if (handshake) begin
          if (idx_q == IdxWidth'(PU_COUNT - 1)) begin
            state_d = StTrailer;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StTrailer: begin
        if (handshake) begin
          test_id_d = test_id_q + 32'd1;
          state_d   = StIdle;
          // The frame is finished on this edge, so a coincident trigger starts
          // the next frame immediately instead of being dropped.
          if (trigger) begin
            capture = 1'b1;
          end else if (1'b0) begin
          end
        end else if (trigger) begin
          drop = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if ((state_q == StHeader || state_q == StRoots) && trigger) begin
      drop = 1'b1;
    end

    if (capture) begin
      state_d      = StHeader;
      snap_roots_d = roots;
      snap_cc_d    = cycle_counter[30:0];
      snap_dl_d    = deadlock;
    end

    if (drop) begin
      overrun_d = 1'b1;
      if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
  end

  // Output word selection.
  logic [ADDRESS_WIDTH-1:0] root_sel;
  logic [7:0]               z8, x8, y8;

  always_comb begin
    root_sel = snap_roots_q[32'(idx_q) * ADDRESS_WIDTH +: ADDRESS_WIDTH];
    z8 = '0;
    x8 = '0;
    y8 = '0;
    // Root address is {k, i, j}; k maps to z, i to x, j to y.
    z8[Pdw-1:0] = root_sel[ADDRESS_WIDTH-1 -: Pdw];
    x8[Pdw-1:0] = root_sel[2*Pdw-1 -: Pdw];
    y8[Pdw-1:0] = root_sel[Pdw-1:0];

    out_data = '0;
    unique case (state_q)
      StIdle:    out_data = '0;
      StHeader:  out_data = test_id_q;
      StRoots:   out_data = {8'h00, z8, x8, y8};
      StTrailer: out_data = {snap_dl_q, snap_cc_q};
      default:   out_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      test_id_q    <= '0;
      snap_roots_q <= '0;
      snap_cc_q    <= '0;
      snap_dl_q    <= 1'b0;
      rv_q         <= 1'b0;
      dl_q         <= 1'b0;
      overrun_q    <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      test_id_q    <= test_id_d;
      snap_roots_q <= snap_roots_d;
      snap_cc_q    <= snap_cc_d;
      snap_dl_q    <= snap_dl_d;
      rv_q         <= result_valid;
      dl_q         <= deadlock;
      overrun_q    <= overrun_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_root_result_streamer.sv
module tb_root_result_streamer;

  localparam int AW = 9;
  localparam int PU = 100;
  localparam int FL = PU + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              result_valid = 1'b0;
  logic              deadlock = 1'b0;
  logic [AW*PU-1:0]  roots = '0;
  logic [31:0]       cycle_counter = '0;
  logic              out_ready = 1'b1;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              busy;
  logic              overrun;
  logic [15:0]       drop_count;

  root_result_streamer dut (
    .clk           (clk),
    .reset         (reset),
    .result_valid  (result_valid),
    .deadlock      (deadlock),
    .roots         (roots),
    .cycle_counter (cycle_counter),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .overrun       (overrun),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model state: expected words of accepted frames, in order.
  logic [31:0] exp_q[$];
  logic [31:0] cur_frame[$];
  logic [31:0] last_frame[$];
  logic [31:0] m_id = '0;
  int          m_drops = 0;
  bit          m_overrun = 1'b0;
  bit          prev_rv = 1'b0;
  bit          prev_dl = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  bit          m_valid, m_trig, m_free;
  logic [31:0] m_word;

  function automatic void push_frame();
    logic [AW-1:0] r;
    exp_q.push_back(m_id);
    for (int n = 0; n < PU; n++) begin
      r = roots[n*AW +: AW];
      // z = k, x = i, y = j, each in its own byte.
      exp_q.push_back({8'h00, 5'h00, r[8:6], 5'h00, r[5:3], 5'h00, r[2:0]});
    end
    exp_q.push_back({deadlock, cycle_counter[30:0]});
    m_id = m_id + 32'd1;
  endfunction

  // Monitor + model: checks what the DUT shows this cycle, then predicts the
  // effect of the inputs it will sample on the coming rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      cur_frame.delete();
      m_id = '0;
      m_drops = 0;
      m_overrun = 1'b0;
      prev_rv = 1'b0;
      prev_dl = 1'b0;
      prev_stall = 1'b0;
    end else begin
      m_valid = exp_q.size() > 0;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_valid));
      chk("overrun", 32'(overrun), 32'(m_overrun));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
      if (prev_stall) chk("stall_hold", out_data, prev_data);
      m_free = !m_valid || (exp_q.size() == 1 && out_ready);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%08h, expected no word", out_data);
        end else begin
          m_word = exp_q.pop_front();
          chk("word", out_data, m_word);
          cur_frame.push_back(out_data);
          if (exp_q.size() == 0) begin
            last_frame = cur_frame;
            cur_frame.delete();
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      m_trig = (result_valid && !prev_rv) || (deadlock && !prev_dl);
      prev_rv = result_valid;
      prev_dl = deadlock;
      if (m_trig) begin
        if (m_free) begin
          push_frame();
        end else begin
          m_overrun = 1'b1;
          if (m_drops != 65535) m_drops++;
        end
      end
    end
  end

  // Sole driver of out_ready.
  int ready_mode = 0;
  int ready_ph = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (ready_ph % 4 == 0) || (ready_ph % 4 == 3);
          ready_ph++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rv();
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
    end
    tick();
    tick();
  endtask

  task automatic chk_frame(input string name, input logic [31:0] hdr,
                           input logic [31:0] w8, input logic [31:0] trl);
    chk({name, "_len"}, 32'(last_frame.size()), 32'(FL));
    if (last_frame.size() == FL) begin
      chk({name, "_header"}, last_frame[0], hdr);
      chk({name, "_pu0"}, last_frame[1], 32'h0);
      chk({name, "_pu7"}, last_frame[8], w8);
      chk({name, "_trailer"}, last_frame[FL-1], trl);
    end
  endtask

  task automatic directed_roots();
    roots = '0;
    roots[7*AW +: AW] = 9'b000_001_011;
  endtask

  task automatic random_roots();
    for (int n = 0; n < PU; n++) roots[n*AW +: AW] = AW'($urandom);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();

    // Basic frame, out_ready held high.
    directed_roots();
    cycle_counter = 32'd37;
    pulse_rv();
    wait_idle(500);
    chk_frame("f0", 32'h0, 32'h0000_0103, 32'h0000_0025);

    // Same frame with a stalling sink.
    ready_mode = 1;
    pulse_rv();
    wait_idle(1000);
    ready_mode = 0;
    chk_frame("f1", 32'h1, 32'h0000_0103, 32'h0000_0025);

    // Deadlock only; level held high must not retrigger.
    cycle_counter = 32'd500;
    deadlock = 1'b1;
    repeat (10) tick();
    deadlock = 1'b0;
    wait_idle(500);
    chk_frame("f2", 32'h2, 32'h0000_0103, 32'h8000_01F4);

    // Trigger mid-frame is dropped; snapshot must survive new inputs.
    random_roots();
    cycle_counter = $urandom;
    pulse_rv();
    repeat (38) tick();
    random_roots();
    cycle_counter = $urandom;
    pulse_rv();
    wait_idle(500);
    chk("overrun_after_drop", 32'(overrun), 32'h1);
    chk("drop_count_after_drop", 32'(drop_count), 32'h1);
    pulse_rv();
    wait_idle(500);
    chk("header_after_drop", last_frame[0], 32'h4);

    // Simultaneous rises: one frame, deadlock flag set.
    result_valid = 1'b1;
    deadlock = 1'b1;
    tick();
    result_valid = 1'b0;
    deadlock = 1'b0;
    wait_idle(500);
    chk("simul_header", last_frame[0], 32'h5);
    chk("simul_dl_flag", 32'(last_frame[FL-1][31]), 32'h1);

    // Trigger exactly on the trailer handshake edge is accepted.
    pulse_rv();
    repeat (FL - 1) tick();
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    wait_idle(500);
    chk("b2b_no_drop", 32'(drop_count), 32'h1);
    chk("b2b_header", last_frame[0], 32'h7);

    // Randomized traffic.
    ready_mode = 2;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 49) == 0) result_valid = ~result_valid;
      if ($urandom_range(0, 149) == 0) deadlock = ~deadlock;
      cycle_counter = $urandom;
      if (c % 25 == 0) random_roots();
      tick();
    end
    result_valid = 1'b0;
    deadlock = 1'b0;
    wait_idle(2000);
    ready_mode = 0;

    // Reset mid-frame.
    random_roots();
    pulse_rv();
    repeat (49) tick();
    reset = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_out_data", out_data, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    pulse_rv();
    wait_idle(500);
    chk("post_reset_header", last_frame[0], 32'h0);
    chk("post_reset_overrun", 32'(overrun), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
